// File: rtl/shift_rot_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_rot_seq_if
// Brief    : Request/response bundle for the multi-cycle shifter/rotator.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_rot_seq_if;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] out;

    modport master (
        output start, in, cnt, op,
        input  busy, done, out
    );

    modport slave (
        input  start, in, cnt, op,
        output busy, done, out
    );
endinterface
`default_nettype wire

// File: rtl/shift_rot_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_rot_seq
// Brief    : 16-bit ROL/SLL/ROR/SRL, one count bit per cycle, MSB stage first.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rot_seq (
    input  logic           clk,
    input  logic           rst,
    shift_rot_seq_if.slave bus
);

    localparam logic [1:0] c_OP_ROL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_ROR = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_busy;
    logic        w_capture;
    logic        w_last;

    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op;
    logic [1:0]  r_k;
    logic [15:0] r_out;
    logic        r_done;

    logic [4:0]  w_dist;
    logic [15:0] w_stage;
    logic [15:0] w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_k == 2'd0) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stage k moves the operand by 2^k; rotates wrap the bits pushed off the end.
    always_comb begin
        w_dist = 5'd1 << r_k;
        case (r_op)
            c_OP_ROL: w_stage = (r_acc << w_dist) | (r_acc >> (5'd16 - w_dist));
            c_OP_SLL: w_stage = r_acc << w_dist;
            c_OP_ROR: w_stage = (r_acc >> w_dist) | (r_acc << (5'd16 - w_dist));
            default:  w_stage = r_acc >> w_dist;
        endcase
        w_acc_nxt = r_cnt[r_k] ? w_stage : r_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= 16'h0000;
            r_cnt  <= 4'd0;
            r_op   <= 2'b00;
            r_k    <= 2'd0;
            r_out  <= 16'h0000;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_capture) begin
                r_acc <= bus.in;
                r_cnt <= bus.cnt;
                r_op  <= bus.op;
                r_k   <= 2'd3;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_nxt;
                if (w_last) begin
                    r_out <= w_acc_nxt;
                end else begin
                    r_k <= r_k - 2'd1;
                end
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_rot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rot_seq
// Brief    : Directed + random scoreboard bench for shift_rot_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rot_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_out = 16'h0000;

    shift_rot_seq_if sif ();

    shift_rot_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    // Reference: apply the operation one bit position at a time, cnt times.
    function automatic logic [15:0] model(input logic [15:0] v, input logic [3:0] c,
                                          input logic [1:0] o);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < int'(c); i++) begin
            case (o)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] c, input logic [1:0] o,
                         input logic [15:0] expv);
        sif.start = 1'b1;
        sif.in    = v;
        sif.cnt   = c;
        sif.op    = o;
        exp_q.push_back(expv);
    endtask

    // Four busy cycles with a stable out, then the done cycle carrying the result.
    task automatic expect_run(input string tag, input bit inject);
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, " busy"}, {15'b0, sif.busy}, 16'h0001);
            check({tag, " done_early"}, {15'b0, sif.done}, 16'h0000);
            check({tag, " out_stable"}, sif.out, last_out);
            if (i == 0) sif.start = 1'b0;
            if (inject && i == 1) begin
                sif.start = 1'b1;
                sif.in    = 16'hFFFF;
                sif.cnt   = 4'd1;
            end
            if (inject && i == 2) sif.start = 1'b0;
        end
        @(negedge clk);
        check({tag, " done"}, {15'b0, sif.done}, 16'h0001);
        check({tag, " busy_in_done"}, {15'b0, sif.busy}, 16'h0000);
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, " out"}, sif.out, e);
            last_out = e;
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " done_pulse_end"}, {15'b0, sif.done}, 16'h0000);
        check({tag, " idle_busy"}, {15'b0, sif.busy}, 16'h0000);
    endtask

    initial begin
        logic [15:0] v;
        logic [3:0]  c;
        logic [1:0]  o;
        sif.start = 1'b0;
        sif.in    = 16'h0000;
        sif.cnt   = 4'd0;
        sif.op    = 2'b00;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out", sif.out, 16'h0000);
        check("reset busy", {15'b0, sif.busy}, 16'h0000);
        check("reset done", {15'b0, sif.done}, 16'h0000);

        drive(16'h8001, 4'd1, 2'b00, 16'h0003);
        expect_run("rol1", 1'b0);
        expect_idle("rol1");

        drive(16'h00FF, 4'd12, 2'b01, 16'hF000);
        expect_run("sll12", 1'b0);
        drive(16'h1234, 4'd8, 2'b10, 16'h3412);
        expect_run("ror8", 1'b0);
        drive(16'h8000, 4'd15, 2'b11, 16'h0001);
        expect_run("srl15", 1'b0);
        drive(16'h1234, 4'd4, 2'b00, 16'h2341);
        expect_run("rol4", 1'b0);
        expect_idle("rol4");

        drive(16'hA5A5, 4'd0, 2'b01, 16'hA5A5);
        expect_run("zero_sll", 1'b0);
        drive(16'hA5A5, 4'd0, 2'b11, 16'hA5A5);
        expect_run("zero_srl", 1'b0);
        expect_idle("zero");

        drive(16'h0001, 4'd3, 2'b01, 16'h0008);
        expect_run("busy_ignore", 1'b1);
        drive(16'h0001, 4'd1, 2'b10, 16'h8000);
        expect_run("b2b_ror", 1'b0);
        expect_idle("b2b_ror");

        sif.start = 1'b1;
        sif.in    = 16'h1234;
        sif.cnt   = 4'd5;
        sif.op    = 2'b00;
        @(negedge clk);
        sif.start = 1'b0;
        check("midrst run1 busy", {15'b0, sif.busy}, 16'h0001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", {15'b0, sif.busy}, 16'h0000);
        check("midrst out", sif.out, 16'h0000);
        check("midrst done", {15'b0, sif.done}, 16'h0000);
        last_out = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst no_done", {15'b0, sif.done}, 16'h0000);
            check("midrst out_held", sif.out, 16'h0000);
        end

        drive(16'h1234, 4'd5, 2'b00, 16'h4682);
        expect_run("post_rst", 1'b0);

        for (int n = 0; n < 8; n++) begin
            v = 16'($urandom);
            c = 4'($urandom_range(15, 0));
            o = 2'($urandom_range(3, 0));
            drive(v, c, o, model(v, c, o));
            expect_run("random", 1'b0);
        end
        expect_idle("random");

        check("scoreboard drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
